// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared definitions for the bit-serial subtractor datapath.
//   - state_e        : sequencer states (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH  : default operand/result width
package serial_arith_pkg;

  // Sequencer states of the serial subtractor
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, purely combinational.
// Ports:
//   i_a    : minuend bit
//   i_b    : subtrahend bit
//   i_bin  : borrow in
//   o_d    : difference bit
//   o_bout : borrow out (set when a < b + bin)
module full_subtractor_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start accepted in IDLE or DONE captures the operands; WIDTH edges later
// the result is registered and done pulses for one cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state and outputs
//   start  : request, only sampled in IDLE or DONE
//   a, b   : minuend / subtrahend, captured on accepted start
//   bin    : borrow in, captured on accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when diff/bout are newly updated
//   diff   : result register, held until the next completion
//   bout   : final borrow (1 iff a < b + bin, unsigned)
module serial_subtractor_16bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;

  full_subtractor_1bit u_fs (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_br_next)
  );

  // Start is honoured only when no operation is in flight.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Flags follow the state being entered so they stay registered.
      r_busy  <= (w_next_state == ST_SHIFT);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Operand capture, bit-serial datapath and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_br   <= bin;
      r_cnt  <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else begin
      r_a_sr <= r_a_sr;
      r_b_sr <= r_b_sr;
      r_d_sr <= r_d_sr;
      r_br   <= r_br;
      r_cnt  <= r_cnt;
    end
  end

  // Result registers, updated only on the final bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      // The last difference bit is still combinational here, so merge it in.
      r_diff <= {w_d, r_d_sr[WIDTH-1:1]};
      r_bout <= w_br_next;
    end else begin
      r_diff <= r_diff;
      r_bout <= r_bout;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule : serial_subtractor_16bit

// File: tb/tb_serial_subtractor_16bit.sv
// Directed self-checking bench for serial_subtractor_16bit.
module tb_serial_subtractor_16bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated operation with full timing checks.
  task automatic do_single(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tbin, input logic [15:0] ediff, input logic ebout);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    step();                          // E0
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    start = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin; // must not matter after acceptance
    repeat (15) step();              // E15
    chk({tag, "_done_e15"}, done, 0);
    chk({tag, "_busy_e15"}, busy, 1);
    step();                          // E16
    chk({tag, "_done_e16"}, done, 1);
    chk({tag, "_busy_e16"}, busy, 0);
    chk({tag, "_diff"}, diff, ediff);
    chk({tag, "_bout"}, bout, ebout);
    step();                          // E17
    chk({tag, "_done_e17"}, done, 0);
    chk({tag, "_diff_hold"}, diff, ediff);
    chk({tag, "_bout_hold"}, bout, ebout);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_bout", bout, 0);
    reset = 1'b0;

    // Idle with start low: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_flags", {busy, done, bout}, 3'b000);
      chk("idle_diff", diff, 16'h0000);
    end

    do_single("sub1", 16'h7095, 16'h158A, 1'b0, 16'h5B0B, 1'b0);
    do_single("sub2", 16'h158A, 16'h7095, 1'b0, 16'hA4F5, 1'b1);
    do_single("zero_bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    do_single("eq_bin", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1);
    do_single("no_borrow", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0);

    // Start held high through SHIFT with changing operands, then back-to-back.
    a = 16'hB903; b = 16'h52AF; bin = 1'b0; start = 1'b1;
    step();                          // E0
    for (int i = 0; i < 16; i++) begin
      a = 16'(i * 16'h1357); b = 16'(i * 16'h2468 + 1); bin = i[0];
      if (i == 15) begin
        a = 16'h52AF; b = 16'hB903; bin = 1'b0; // captured at E17 (DONE cycle)
      end
      step();                        // E1..E16
      if (i == 14) chk("b2b_done_e15", done, 0);
    end
    chk("b2b_done1", done, 1);
    chk("b2b_diff1", diff, 16'h6654);
    chk("b2b_bout1", bout, 0);
    step();                          // E17: new start accepted
    start = 1'b0;
    chk("b2b_busy_e17", busy, 1);
    chk("b2b_done_e17", done, 0);
    chk("b2b_diff_hold", diff, 16'h6654);
    repeat (15) step();              // E32
    chk("b2b_done_e32", done, 0);
    step();                          // E33
    chk("b2b_done2", done, 1);
    chk("b2b_diff2", diff, 16'h99AC);
    chk("b2b_bout2", bout, 1);
    step();
    chk("b2b_done_drop", done, 0);

    // Reset in the middle of an operation.
    a = 16'h0001; b = 16'h0003; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_diff", diff, 16'h0000);
    chk("mid_bout", bout, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_quiet", {busy, done}, 2'b00);
    end
    do_single("after_rst", 16'h0001, 16'h0003, 1'b0, 16'hFFFE, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor_16bit
